alu_serial_seq: RTL and testbench

- Bit-serial sequencer for the 1-bit ALU slice `alu` (inputs a, b, c, s[2:0]; outputs out, cout; combinational).
- Accepts one WORD-wide operation over a valid/ready request channel and drives it through the slice LSB-first, one bit per cycle.
- Chains the slice's cout into the next bit's c and assembles the WORD-wide result plus the final carry.
- Returns the result over a valid/ready response channel; the stack datapath uses it for all word-wide ALU ops.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/alu_serial_seq_if.sv | 33 +++
 rtl/alu.sv | 25 ++
 rtl/alu_serial_seq.sv | 86 ++++++++
 tb/tb_alu_serial_seq.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the bit-serial ALU path.
// Holds word/op widths, op codes and the sequencer state type.
package cpu_pkg;

  localparam int WORD_DEF = 4;
  localparam int OP_W_DEF = 3;

  typedef enum logic [OP_W_DEF-1:0] {
    OP_NEQ = 3'd0
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/response channel between the stack datapath
// and the bit-serial ALU sequencer.
interface alu_serial_seq_if #(
  parameter int WORD = 4,
  parameter int OP_W = 3
);

  logic            req_valid;
  logic            req_ready;
  logic [WORD-1:0] req_a;
  logic [WORD-1:0] req_b;
  logic [OP_W-1:0] req_op;
  logic            req_cin;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [WORD-1:0] rsp_result;
  logic            rsp_carry;

  modport master (
    output req_valid, req_a, req_b,
    output req_op, req_cin, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_result, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b,
    input  req_op, req_cin, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_result, rsp_carry
  );

endinterface

// File: rtl/alu.sv
// 1-bit ALU slice, combinational.
// Only OP_NEQ is defined; other codes drive zeros.
module alu
  import cpu_pkg::*;
#(
  parameter int OP_W = OP_W_DEF
) (
  input  logic            a,
  input  logic            b,
  input  logic            c,
  input  logic [OP_W-1:0] s,
  output logic            out,
  output logic            cout
);

  always_comb begin
    out  = 1'b0;
    cout = 1'b0;
    if (s == OP_W'(OP_NEQ)) begin
      out  = a ^ b;
      cout = c & (a ^ b);
    end
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer: runs a word op through the 1-bit
// slice LSB-first, chaining cout back into c.
module alu_serial_seq
  import cpu_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input logic          clk,
  input logic          rst,
  alu_serial_seq_if.slave bus
);

  localparam int CW = $clog2(WORD);
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);

  state_e          state;
  logic [WORD-1:0] a_sh;
  logic [WORD-1:0] b_sh;
  logic [WORD-1:0] result;
  logic [OP_W-1:0] op_q;
  logic            carry;
  logic [CW-1:0]   cnt;
  logic            valid_q;
  logic            s_out;
  logic            s_cout;

  alu #(.OP_W(OP_W)) u_alu (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .c    (carry),
    .s    (op_q),
    .out  (s_out),
    .cout (s_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      result  <= '0;
      op_q    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            a_sh  <= bus.req_a;
            b_sh  <= bus.req_b;
            op_q  <= bus.req_op;
            carry <= bus.req_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= {s_out, result[WORD-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= s_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE) && !rst;
  assign bus.rsp_valid  = valid_q;
  assign bus.rsp_result = result;
  assign bus.rsp_carry  = carry;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed cases
// plus randomized ops with random response backpressure.
module tb_alu_serial_seq;
  import cpu_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_serial_seq_if #(.WORD(W), .OP_W(OP_W_DEF)) bus();

  alu_serial_seq #(.WORD(W), .OP_W(OP_W_DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_hs = -100;
  bit   rnd_rdy = 1'b0;
  rsp_t exp_q[$];
  int   acc_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h at cyc %0d",
               nm, act, req, cyc);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errs++;
    $display("FAIL %s: got event, want none at cyc %0d",
             nm, cyc);
  endtask

  // Word-level meaning of OP_NEQ: xor, carry survives
  // only if every bit pair differs.
  function automatic rsp_t model(input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic cin);
    rsp_t e;
    e.r = a ^ b;
    e.c = cin && ((a ^ b) == {W{1'b1}});
    return e;
  endfunction

  rsp_t held;
  bit   held_v = 1'b0;
  bit   prev_v = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      acc_q.delete();
      held_v = 1'b0;
      prev_v = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready)
        acc_q.push_back(cyc);
      if (bus.rsp_valid) begin
        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
        if (!prev_v) begin
          if (acc_q.size() == 0) fail("latency_noacc");
          else chk("latency", 32'(cyc - acc_q.pop_front()), 32'd5);
        end
        if (held_v)
          chk("hold", 32'({bus.rsp_result, bus.rsp_carry}),
              32'(held));
        if (bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("result", 32'(bus.rsp_result), 32'(e.r));
            chk("carry", 32'(bus.rsp_carry), 32'(e.c));
          end
          last_hs = cyc;
          held_v = 1'b0;
        end else begin
          held = {bus.rsp_result, bus.rsp_carry};
          held_v = 1'b1;
        end
      end
      prev_v = bus.rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic cin,
                      output int acc);
    bus.req_a = a;
    bus.req_b = b;
    bus.req_op = OP_W_DEF'(OP_NEQ);
    bus.req_cin = cin;
    bus.req_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200 && acc < 0; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = cyc;
        exp_q.push_back(model(a, b, cin));
      end
      tick();
    end
    if (acc < 0) chk("accept_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b0;
    bus.req_a = W'($urandom);
    bus.req_b = W'($urandom);
    bus.req_op = OP_W_DEF'($urandom);
    bus.req_cin = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  int a1, a2, n;

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_op = '0;
    bus.req_cin = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_result", 32'(bus.rsp_result), 32'd0);
    chk("rst_carry", 32'(bus.rsp_carry), 32'd0);
    chk("rst_ready_hi", 32'(bus.req_ready), 32'd1);
    tick();

    send(4'b1010, 4'b0101, 1'b1, a1);
    drain();
    send(4'b1010, 4'b0111, 1'b1, a1);
    send(4'b1010, 4'b0111, 1'b0, a1);
    drain();

    send(4'b0011, 4'b0000, 1'b0, a1);
    bus.req_a = 4'b1111;
    drain();

    bus.rsp_ready = 1'b0;
    send(4'b0110, 4'b0011, 1'b1, a1);
    bus.req_a = 4'b1001;
    bus.req_b = 4'b0110;
    bus.req_cin = 1'b1;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) chk("rsp_timeout", 32'd0, 32'd1);
    repeat (3) tick();
    bus.rsp_ready = 1'b1;
    send(4'b1001, 4'b0110, 1'b1, a2);
    chk("accept_after_bp", 32'(a2 - last_hs), 32'd1);
    drain();

    send(4'b1111, 4'b0000, 1'b1, a1);
    tick();
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_result", 32'(bus.rsp_result), 32'd0);
    chk("midrst_carry", 32'(bus.rsp_carry), 32'd0);
    chk("midrst_ready_hi", 32'(bus.req_ready), 32'd1);
    repeat (10) tick();

    send(4'b1100, 4'b1010, 1'b0, a1);
    send(4'b0001, 4'b0001, 1'b0, a2);
    chk("b2b_accept", 32'(a2 - last_hs), 32'd1);
    drain();

    rnd_rdy = 1'b1;
    repeat (40) begin
      repeat ($urandom_range(0, 2)) tick();
      send(W'($urandom), W'($urandom), 1'($urandom), a1);
    end
    drain();
    rnd_rdy = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
